// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit frames,
// folds E0/F0 prefixes into key events and queues them in a first-word-fall-through FIFO.
module ps2_key_decoder #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    output logic [7:0]                    KEY_CODE,
    output logic                          KEY_EXT,
    output logic                          KEY_BREAK,
    output logic                          KEY_VALID,
    input  logic                          KEY_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          PARITY_ERR,
    output logic                          FRAME_ERR,
    output logic                          OVERFLOW
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EVT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_dat_s;
    logic                   ps2_fall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev_q <= ps2_clk_s;
        end
    end

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign ps2_fall  = clk_prev_q & ~ps2_clk_s;

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_ok_q, byte_ok_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            timeout_hit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            byte_ok_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            byte_ok_q <= byte_ok_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        byte_ok_d = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (ps2_fall && !ps2_dat_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (ps2_fall) begin
                    shift_d = {ps2_dat_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (ps2_fall) begin
                    par_d   = ps2_dat_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (ps2_fall) begin
                    state_d = ST_IDLE;
                    if (!ps2_dat_s) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        byte_ok_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-edge watchdog: an edge restarts it, a stalled frame is abandoned.
        if (state_q != ST_IDLE) begin
            if (ps2_fall) begin
                to_cnt_d = '0;
            end else if (timeout_hit) begin
                state_d  = ST_IDLE;
                ferr_d   = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Prefix tracking
    // ---------------------------------------------------------------
    logic pend_ext_q;
    logic pend_brk_q;
    logic is_e0;
    logic is_f0;
    logic push;

    assign is_e0 = (shift_q == 8'hE0);
    assign is_f0 = (shift_q == 8'hF0);
    assign push  = byte_ok_q && !is_e0 && !is_f0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
        end else if (perr_q || ferr_q) begin
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
        end else if (byte_ok_q) begin
            if (is_e0) begin
                pend_ext_q <= 1'b1;
            end else if (is_f0) begin
                pend_brk_q <= 1'b1;
            end else begin
                pend_ext_q <= 1'b0;
                pend_brk_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Event FIFO with a registered head
    // ---------------------------------------------------------------
    logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [EVT_W-1:0] head_q, head_d;
    logic             valid_q;
    logic             ovf_q;
    logic [EVT_W-1:0] push_evt;
    logic             pop;
    logic             full;
    logic             wr_en;

    assign push_evt = {pend_ext_q, pend_brk_q, shift_q};
    assign pop      = valid_q && KEY_READY;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_en    = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Next head: the entry behind the popped one, or the incoming event if it lands first.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count_q == CNT_W'(1)) begin
                head_d = push_evt;
            end else begin
                head_d = mem_q[rd_ptr_q + PTR_W'(1)];
            end
        end else if (count_q == '0 && wr_en) begin
            head_d = push_evt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_evt;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= (count_d != '0);
            ovf_q   <= push && full && !pop;
        end
    end

    assign KEY_CODE   = head_q[7:0];
    assign KEY_BREAK  = head_q[8];
    assign KEY_EXT    = head_q[9];
    assign KEY_VALID  = valid_q;
    assign FIFO_COUNT = count_q;
    assign PARITY_ERR = perr_q;
    assign FRAME_ERR  = ferr_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks decoded events,
// error pulses, FIFO occupancy, overflow and reset behaviour against hand-derived values.
module tb_ps2_key_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TOUT  = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;

    ps2_key_decoder #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .KEY_CODE  (key_code),
        .KEY_EXT   (key_ext),
        .KEY_BREAK (key_break),
        .KEY_VALID (key_valid),
        .KEY_READY (key_ready),
        .FIFO_COUNT(fifo_count),
        .PARITY_ERR(parity_err),
        .FRAME_ERR (frame_err),
        .OVERFLOW  (overflow)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output; a one-cycle pulse adds exactly one.
    always @(posedge clk) begin
        if (rst_n) begin
            perr_cnt <= perr_cnt + int'(parity_err);
            ferr_cnt <= ferr_cnt + int'(frame_err);
            ovf_cnt  <= ovf_cnt + int'(overflow);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit; optionally pulses KEY_READY on the cycle this bit's edge pushes.
    task automatic ps2_bit(input logic b, input logic pop_on_push);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_on_push) begin
            repeat (3) @(negedge clk);
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                        input logic pop_on_push);
        logic par;
        par = bad_par ? ^b : ~^b;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(!bad_stop, pop_on_push);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] code, input logic ext,
                            input logic brk);
        chk({tag, "_valid"}, 32'(key_valid), 32'd1);
        chk({tag, "_code"}, 32'(key_code), 32'(code));
        chk({tag, "_ext"}, 32'(key_ext), 32'(ext));
        chk({tag, "_brk"}, 32'(key_break), 32'(brk));
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'h00);
        chk("rst_ext", 32'(key_ext), 32'd0);
        chk("rst_brk", 32'(key_break), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single make code, held while not ready
        send(8'h1C, 1'b0, 1'b0, 1'b0);
        chk_head("k1c", 8'h1C, 1'b0, 1'b0);
        chk("k1c_count", 32'(fifo_count), 32'd1);
        repeat (10) @(negedge clk);
        chk("k1c_hold_code", 32'(key_code), 32'h1C);
        chk("k1c_hold_valid", 32'(key_valid), 32'd1);
        pop_one();
        chk("k1c_pop_valid", 32'(key_valid), 32'd0);
        chk("k1c_pop_count", 32'(fifo_count), 32'd0);
        pop_one();
        chk("empty_pop_count", 32'(fifo_count), 32'd0);

        // Extended break sequence, then a plain make
        send(8'hE0, 1'b0, 1'b0, 1'b0);
        chk("e0_no_event", 32'(fifo_count), 32'd0);
        send(8'hF0, 1'b0, 1'b0, 1'b0);
        chk("f0_no_event", 32'(fifo_count), 32'd0);
        send(8'h75, 1'b0, 1'b0, 1'b0);
        chk("e0f075_count", 32'(fifo_count), 32'd1);
        chk_head("e0f075", 8'h75, 1'b1, 1'b1);
        pop_one();
        send(8'h29, 1'b0, 1'b0, 1'b0);
        chk_head("k29", 8'h29, 1'b0, 1'b0);
        pop_one();
        chk("k29_pop_count", 32'(fifo_count), 32'd0);

        // Parity and stop-bit errors
        send(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("perr_pulses", 32'(perr_cnt), 32'd1);
        chk("perr_no_event", 32'(fifo_count), 32'd0);
        send(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("ferr_pulses", 32'(ferr_cnt), 32'd1);
        chk("ferr_no_event", 32'(fifo_count), 32'd0);
        chk("ferr_no_perr", 32'(perr_cnt), 32'd1);

        // An error drops a pending prefix
        send(8'hE0, 1'b0, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0, 1'b0);
        send(8'h29, 1'b0, 1'b0, 1'b0);
        chk("prefix_clr_perr", 32'(perr_cnt), 32'd2);
        chk_head("prefix_clr", 8'h29, 1'b0, 1'b0);
        pop_one();

        // Stalled frame times out, next frame decodes
        send_partial(8'h6B, 4);
        repeat (TOUT + 100) @(negedge clk);
        chk("tout_ferr", 32'(ferr_cnt), 32'd2);
        chk("tout_no_event", 32'(fifo_count), 32'd0);
        send(8'h6B, 1'b0, 1'b0, 1'b0);
        chk_head("k6b", 8'h6B, 1'b0, 1'b0);
        chk("k6b_ferr", 32'(ferr_cnt), 32'd2);
        pop_one();

        // Overflow on the fifth queued event
        send(8'h15, 1'b0, 1'b0, 1'b0);
        send(8'h1D, 1'b0, 1'b0, 1'b0);
        send(8'h24, 1'b0, 1'b0, 1'b0);
        send(8'h2D, 1'b0, 1'b0, 1'b0);
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_no_ovf", 32'(ovf_cnt), 32'd0);
        send(8'h2C, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
        chk("drain0", 32'(key_code), 32'h15);
        pop_one();
        chk("drain1", 32'(key_code), 32'h1D);
        pop_one();
        chk("drain2", 32'(key_code), 32'h24);
        pop_one();
        chk("drain3", 32'(key_code), 32'h2D);
        pop_one();
        chk("drain_empty", 32'(fifo_count), 32'd0);
        chk("drain_valid", 32'(key_valid), 32'd0);

        // Full FIFO with a pop on the push cycle
        send(8'h16, 1'b0, 1'b0, 1'b0);
        send(8'h1E, 1'b0, 1'b0, 1'b0);
        send(8'h26, 1'b0, 1'b0, 1'b0);
        send(8'h25, 1'b0, 1'b0, 1'b0);
        send(8'h2E, 1'b0, 1'b0, 1'b1);
        chk("fullpp_count", 32'(fifo_count), 32'd4);
        chk("fullpp_ovf", 32'(ovf_cnt), 32'd1);
        chk("fullpp0", 32'(key_code), 32'h1E);
        pop_one();
        chk("fullpp1", 32'(key_code), 32'h26);
        pop_one();
        chk("fullpp2", 32'(key_code), 32'h25);
        pop_one();
        chk("fullpp3", 32'(key_code), 32'h2E);
        pop_one();
        chk("fullpp_empty", 32'(fifo_count), 32'd0);

        // Reset mid-frame with an event queued
        send(8'h1C, 1'b0, 1'b0, 1'b0);
        send_partial(8'h5A, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_valid", 32'(key_valid), 32'd0);
        chk("midrst_code", 32'(key_code), 32'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h5A, 1'b0, 1'b0, 1'b0);
        chk_head("post_rst", 8'h5A, 1'b0, 1'b0);
        chk("post_rst_count", 32'(fifo_count), 32'd1);
        chk("post_rst_ferr", 32'(ferr_cnt), 32'd2);
        chk("post_rst_perr", 32'(perr_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, CLK cycles allowed between PS/2 clock falling edges within a frame.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on PS2_CLK and PS2_DATA (>=2).
REQ-004 SHALL have port CLK input 1: system clock, all logic on rising edge; one clock only.
REQ-005 SHALL have port RST_N input 1: asynchronous, active-low reset.
REQ-006 SHALL have port PS2_CLK input 1: raw keyboard clock, asynchronous to CLK.
REQ-007 SHALL have port PS2_DATA input 1: raw keyboard data, asynchronous to CLK.
REQ-008 SHALL have port KEY_CODE output 8: scan code of head event.
REQ-009 SHALL have port KEY_EXT output 1: head event was prefixed by E0.
REQ-010 SHALL have port KEY_BREAK output 1: head event was prefixed by F0 (release).
REQ-011 SHALL have port KEY_VALID output 1: FIFO non-empty, head event presented.
REQ-012 SHALL have port KEY_READY input 1: consumer accepts head event.
REQ-013 SHALL have port FIFO_COUNT output $clog2(FIFO_DEPTH)+1: occupied entries.
REQ-014 SHALL have port PARITY_ERR output 1: one-cycle pulse, bad parity frame.
REQ-015 SHALL have port FRAME_ERR output 1: one-cycle pulse, bad stop bit or timeout.
REQ-016 SHALL have port OVERFLOW output 1: one-cycle pulse, event dropped on full FIFO.

Function
REQ-017 PS2_CLK/PS2_DATA SHALL pass through SYNC_STAGES flops; falling edge = registered synced clock 1 -> synced clock 0.
REQ-018 Frame FSM SHALL have states IDLE, DATA, PARITY, STOP; all transitions on detected falling edge only, sampling synced data.
REQ-019 IDLE: data 0 -> DATA with bit count 0; data 1 -> stay IDLE, no error.
REQ-020 DATA: shift bits LSB first; after 8th bit -> PARITY.
REQ-021 PARITY: capture bit -> STOP; frame parity SHALL be odd over 8 data + parity bits.
REQ-022 STOP: -> IDLE always; stop 0 -> FRAME_ERR pulse, byte discarded; stop 1 with bad parity -> PARITY_ERR pulse, byte discarded; else byte accepted.
REQ-023 Timeout counter SHALL reset on every falling edge and in IDLE; reaching TIMEOUT_CYCLES outside IDLE -> IDLE, FRAME_ERR pulse, partial byte discarded.
REQ-024 Accepted byte E0 SHALL set pending-ext; F0 SHALL set pending-break; neither pushes an event.
REQ-025 Any other accepted byte SHALL push {ext, break, code} and clear both pending flags in the same cycle.
REQ-026 Any PARITY_ERR or FRAME_ERR SHALL clear both pending flags.
REQ-027 Push SHALL occur the cycle after stop-bit edge detection; KEY_VALID SHALL rise the cycle after push when FIFO was empty.
REQ-028 FIFO SHALL be first-word-fall-through; KEY_CODE/KEY_EXT/KEY_BREAK SHALL be stable while KEY_VALID=1 and KEY_READY=0.
REQ-029 Pop SHALL occur on cycles with KEY_VALID=1 and KEY_READY=1; KEY_READY with empty FIFO SHALL be ignored.
REQ-030 Push while full without pop SHALL drop new event, pulse OVERFLOW, leave FIFO unchanged.
REQ-031 Simultaneous push and pop SHALL both succeed, including when full; FIFO_COUNT unchanged.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FIFO_COUNT SHALL range 0..FIFO_DEPTH.

Reset
REQ-033 RST_N=0 SHALL asynchronously force FSM IDLE, counters 0, pending flags 0, FIFO empty, synchronizers to 1.
REQ-034 During reset outputs SHALL be KEY_CODE=8'h00, KEY_EXT=0, KEY_BREAK=0, KEY_VALID=0, FIFO_COUNT=0, PARITY_ERR=0, FRAME_ERR=0, OVERFLOW=0.
REQ-035 Reset mid-frame SHALL discard partial frame and FIFO contents; first frame after release SHALL decode normally.

Verification
REQ-036 Frame 8'h1C, odd parity, KEY_READY=0 -> KEY_VALID=1, KEY_CODE=8'h1C, EXT=0, BREAK=0, FIFO_COUNT=1.
REQ-037 Frames E0,F0,75 -> exactly one event: CODE=8'h75, EXT=1, BREAK=1; next frame 29 -> CODE=8'h29, EXT=0, BREAK=0.
REQ-038 Frame 8'h1C with wrong parity -> one-cycle PARITY_ERR, no event; stop bit 0 -> FRAME_ERR, no event.
REQ-039 PS2_CLK stops after 4 data bits for >TIMEOUT_CYCLES -> FRAME_ERR pulse, FSM IDLE; following good frame 8'h6B decoded.
REQ-040 FIFO_DEPTH=4, KEY_READY=0, 5 frames -> FIFO_COUNT=4, OVERFLOW pulse on 5th; drain yields first 4 codes in order.
REQ-041 FIFO full with KEY_READY=1 on push cycle -> no OVERFLOW, FIFO_COUNT stays 4, order preserved.
